// File: rtl/mole_scheduler_pkg.sv
// mole_scheduler_pkg: shared types and constants for the whack-a-mole round scheduler.
//   state_e   : round sequencing states (IDLE, GAP, UP, DONE)
//   TIME_W    : width of the game timer and the tick counters
//   LFSR_W    : width of the mole-select LFSR
//   LFSR_TAPS : Fibonacci tap mask (taps 8,6,5,4 -> bits 7,5,4,3)
//   lfsr_next : one LFSR step
package mole_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int NUM_MOLES_DEF = 5;
  localparam int TIME_W        = 16;
  localparam int LFSR_W        = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // Shift left, feeding the parity of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if: bundle between the game controller side and the mole scheduler.
//   enable        : game active level from the game FSM
//   tick          : 1-cycle timing pulse
//   hit_buttons   : 1-cycle debounced button pulses, one bit per mole
//   mole_position : one-hot lit mole, 0 when none
//   player_scored / player_missed / wrong_press : 1-cycle result pulses
//   timer_expired : level, high while the round is over
//   time_left     : remaining game ticks
// Modports: master drives the inputs of the scheduler, slave is the scheduler.
interface mole_scheduler_if import mole_scheduler_pkg::*; #(
  parameter int NUM_MOLES = NUM_MOLES_DEF
) ();

  logic                 enable;
  logic                 tick;
  logic [NUM_MOLES-1:0] hit_buttons;
  logic [NUM_MOLES-1:0] mole_position;
  logic                 player_scored;
  logic                 player_missed;
  logic                 wrong_press;
  logic                 timer_expired;
  logic [TIME_W-1:0]    time_left;

  modport master (
    output enable, tick, hit_buttons,
    input  mole_position, player_scored, player_missed, wrong_press,
           timer_expired, time_left
  );

  modport slave (
    input  enable, tick, hit_buttons,
    output mole_position, player_scored, player_missed, wrong_press,
           timer_expired, time_left
  );

endinterface

// File: rtl/mole_scheduler_lfsr.sv
// mole_lfsr: free-running 8-bit Fibonacci LFSR used as the mole-select entropy source.
//   clock : system clock
//   reset : async, active-high; loads SEED
//   value : current LFSR state
module mole_lfsr import mole_scheduler_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_r;

  // Advance every clock so the moment a mole is picked depends on player timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: sequences one whack-a-mole round and counts down the game clock.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : enable/tick/hit_buttons in; mole_position, player_scored,
//                  player_missed, wrong_press, timer_expired, time_left out
// Optional feature: define MOLE_SPEEDUP_EN to shorten the up-window by UP_STEP
// on every hit, never below UP_TICKS_MIN. Undefined: window fixed at UP_TICKS_INIT.
// All outputs are registered; a decision shows up the cycle after its input.
module mole_scheduler import mole_scheduler_pkg::*; #(
  parameter int                NUM_MOLES     = NUM_MOLES_DEF,
  parameter int                GAME_TICKS    = 600,
  parameter int                UP_TICKS_INIT = 20,
  parameter int                UP_TICKS_MIN  = 5,
  parameter int                UP_STEP       = 2,
  parameter int                GAP_TICKS     = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
  input logic              clock,
  input logic              reset,
  mole_scheduler_if.slave  bus
);

`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [NUM_MOLES-1:0] MOLE_ONE = {{(NUM_MOLES-1){1'b0}}, 1'b1};

  state_e               state_r, state_s;
  logic [NUM_MOLES-1:0] mole_r, mole_s;
  logic                 scored_r, scored_s;
  logic                 missed_r, missed_s;
  logic                 wrong_r, wrong_s;
  logic                 expired_r, expired_s;
  logic [TIME_W-1:0]    time_r, time_s;
  logic [TIME_W-1:0]    gap_cnt_r, gap_cnt_s;
  logic [TIME_W-1:0]    up_cnt_r, up_cnt_s;
  logic [TIME_W-1:0]    up_len_r, up_len_s;
  logic [LFSR_W-1:0]    prev_idx_r, prev_idx_s;
  logic                 prev_valid_r, prev_valid_s;

  logic [LFSR_W-1:0]    lfsr_s;
  logic [LFSR_W-1:0]    idx_raw_s, idx_sel_s;
  logic [NUM_MOLES-1:0] mole_onehot_s;
  logic                 hit_s, wrong_raw_s, time_last_s;
  logic [TIME_W-1:0]    time_dec_s, len_after_hit_s;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_s)
  );

  // Mole pick, press classification, saturating timer step and speed-up window.
  always_comb begin
    idx_raw_s = lfsr_s % LFSR_W'(NUM_MOLES);
    if (prev_valid_r && (idx_raw_s == prev_idx_r)) begin
      idx_sel_s = (idx_raw_s == LFSR_W'(NUM_MOLES - 1)) ? LFSR_W'(0) : idx_raw_s + LFSR_W'(1);
    end else begin
      idx_sel_s = idx_raw_s;
    end
    mole_onehot_s = MOLE_ONE << idx_sel_s;
    hit_s         = |(bus.hit_buttons & mole_r);
    wrong_raw_s   = |(bus.hit_buttons & ~mole_r);
    time_last_s   = bus.tick && (time_r == TIME_W'(1));
    time_dec_s    = (time_r != TIME_W'(0)) ? time_r - TIME_W'(1) : TIME_W'(0);
    // max(up_len - UP_STEP, UP_TICKS_MIN) without going through zero.
    if (SPEEDUP && (up_len_r >= TIME_W'(UP_TICKS_MIN + UP_STEP))) begin
      len_after_hit_s = up_len_r - TIME_W'(UP_STEP);
    end else if (SPEEDUP) begin
      len_after_hit_s = TIME_W'(UP_TICKS_MIN);
    end else begin
      len_after_hit_s = up_len_r;
    end
  end

  // Next-state and next-output decisions, highest-priority event first.
  always_comb begin
    state_s      = state_r;
    mole_s       = mole_r;
    scored_s     = 1'b0;
    missed_s     = 1'b0;
    wrong_s      = 1'b0;
    expired_s    = expired_r;
    time_s       = time_r;
    gap_cnt_s    = gap_cnt_r;
    up_cnt_s     = up_cnt_r;
    up_len_s     = up_len_r;
    prev_idx_s   = prev_idx_r;
    prev_valid_s = prev_valid_r;
    if (!bus.enable) begin
      state_s   = ST_IDLE;
      mole_s    = '0;
      expired_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s   = ST_GAP;
          mole_s    = '0;
          expired_s = 1'b0;
          time_s    = TIME_W'(GAME_TICKS);
          gap_cnt_s = TIME_W'(GAP_TICKS);
          up_len_s  = TIME_W'(UP_TICKS_INIT);
        end
        ST_GAP: begin
          if (bus.tick) begin
            time_s = time_dec_s;
            if (time_last_s) begin
              state_s   = ST_DONE;
              expired_s = 1'b1;
              mole_s    = '0;
            end else if (gap_cnt_r == TIME_W'(1)) begin
              state_s      = ST_UP;
              mole_s       = mole_onehot_s;
              up_cnt_s     = up_len_r;
              prev_idx_s   = idx_sel_s;
              prev_valid_s = 1'b1;
            end else begin
              gap_cnt_s = (gap_cnt_r != TIME_W'(0)) ? gap_cnt_r - TIME_W'(1) : TIME_W'(0);
            end
          end else begin
            gap_cnt_s = gap_cnt_r;
          end
        end
        ST_UP: begin
          if (bus.tick) begin
            time_s = time_dec_s;
          end else begin
            time_s = time_r;
          end
          if (hit_s) begin
            // A hit wins over window expiry and over wrong bits in the same cycle.
            scored_s  = 1'b1;
            mole_s    = '0;
            up_len_s  = len_after_hit_s;
            gap_cnt_s = TIME_W'(GAP_TICKS);
            state_s   = time_last_s ? ST_DONE : ST_GAP;
            expired_s = time_last_s;
          end else if (time_last_s) begin
            // Game end swallows a coincident window expiry.
            state_s   = ST_DONE;
            mole_s    = '0;
            expired_s = 1'b1;
          end else if (bus.tick && (up_cnt_r == TIME_W'(1))) begin
            missed_s  = 1'b1;
            mole_s    = '0;
            gap_cnt_s = TIME_W'(GAP_TICKS);
            state_s   = ST_GAP;
          end else begin
            wrong_s = wrong_raw_s;
            if (bus.tick && (up_cnt_r != TIME_W'(0))) begin
              up_cnt_s = up_cnt_r - TIME_W'(1);
            end else begin
              up_cnt_s = up_cnt_r;
            end
          end
        end
        ST_DONE: begin
          mole_s    = '0;
          expired_s = 1'b1;
        end
        default: begin
          state_s = ST_IDLE;
          mole_s  = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      mole_r       <= '0;
      scored_r     <= 1'b0;
      missed_r     <= 1'b0;
      wrong_r      <= 1'b0;
      expired_r    <= 1'b0;
      time_r       <= TIME_W'(0);
      gap_cnt_r    <= TIME_W'(0);
      up_cnt_r     <= TIME_W'(0);
      up_len_r     <= TIME_W'(UP_TICKS_INIT);
      prev_idx_r   <= LFSR_W'(0);
      prev_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      mole_r       <= mole_s;
      scored_r     <= scored_s;
      missed_r     <= missed_s;
      wrong_r      <= wrong_s;
      expired_r    <= expired_s;
      time_r       <= time_s;
      gap_cnt_r    <= gap_cnt_s;
      up_cnt_r     <= up_cnt_s;
      up_len_r     <= up_len_s;
      prev_idx_r   <= prev_idx_s;
      prev_valid_r <= prev_valid_s;
    end
  end

  assign bus.mole_position = mole_r;
  assign bus.player_scored = scored_r;
  assign bus.player_missed = missed_r;
  assign bus.wrong_press   = wrong_r;
  assign bus.timer_expired = expired_r;
  assign bus.time_left     = time_r;

endmodule
